// File: rtl/div_sequencer.sv
// Multi-cycle RV32IM divide sequencer (DIV/DIVU/REM/REMU): 32-step restoring
// divider with a fast path for divide-by-zero and signed overflow.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);

  // Handshake: start is taken only in IDLE (busy=0); busy stays high until the
  // edge that raises done; done is a one-cycle pulse with result valid alongside.
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  state_t          r_state, w_next;
  logic            r_op_rem, r_q_neg, r_r_neg, r_special, r_done;
  logic [XLEN-1:0] r_quo, r_rem, r_dvsr, r_result;
  logic [CW-1:0]   r_cnt;

  logic            w_signed, w_div_zero, w_ovf;
  logic [XLEN-1:0] w_dvd_mag, w_dvsr_mag, w_q_fix, w_r_fix;
  logic [XLEN:0]   w_rem_sh, w_diff;

  assign w_signed   = ~op[0];
  assign w_dvd_mag  = (w_signed && dividend[XLEN-1]) ? -dividend : dividend;
  assign w_dvsr_mag = (w_signed && divisor[XLEN-1])  ? -divisor  : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = w_signed && (dividend == INT_MIN) && (divisor == '1);

  // rem < divisor always holds, so the shifted value minus divisor fits a
  // signed XLEN+1 result and its top bit is a valid borrow.
  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvsr};

  assign w_q_fix = (!r_special && r_q_neg) ? -r_quo : r_quo;
  assign w_r_fix = (!r_special && r_r_neg) ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (w_div_zero || w_ovf) ? FIN : CALC;
      CALC:    if (r_cnt == '0) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op_rem  <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_special <= 1'b0;
      r_done    <= 1'b0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvsr    <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
    end else begin
      r_done <= 1'b0;
      if (!flush) begin
        case (r_state)
          IDLE: if (start) begin
            r_op_rem  <= op[1];
            r_dvsr    <= w_dvsr_mag;
            r_q_neg   <= w_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            r_r_neg   <= w_signed && dividend[XLEN-1];
            r_special <= w_div_zero || w_ovf;
            if (w_div_zero) begin
              r_quo <= '1;
              r_rem <= dividend;
            end else if (w_ovf) begin
              r_quo <= INT_MIN;
              r_rem <= '0;
            end else begin
              r_quo <= w_dvd_mag;
              r_rem <= '0;
              r_cnt <= CW'(XLEN - 1);
            end
          end
          CALC: begin
            r_rem <= w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
            r_cnt <= r_cnt - 1'b1;
          end
          FIN: begin
            r_result <= r_op_rem ? w_r_fix : w_q_fix;
            r_done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy      = (r_state == CALC) || (r_state == FIN);
  assign done      = r_done;
  assign result    = r_result;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, results, fast paths, flush,
// start-while-busy, back-to-back and asynchronous reset.
module tb_div_sequencer;

  localparam int XLEN = 32;

  logic            clk, reset_n, start, flush, busy, done;
  logic [1:0]      op, state_dbg;
  logic [XLEN-1:0] dividend, divisor, result;

  logic [XLEN-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  div_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy), .done(done), .result(result), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, wait for done (bounded), check latency, busy width and result.
  // If poke is set, a conflicting start is driven mid-operation and must be ignored.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                        input int exp_edges, input bit poke);
    int n, busy_cyc;
    logic [XLEN-1:0] e;
    exp_q.push_back(exp_res);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = '0; divisor = '0;
    n = 0; busy_cyc = 0;
    while (!done && n < 100) begin
      if (busy) busy_cyc++;
      if (poke && n == 5) begin
        start = 1'b1; op = 2'b01; dividend = 32'd77; divisor = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_latency"}, n, exp_edges);
    check({tag, "_busy_cycles"}, busy_cyc, exp_edges);
    check({tag, "_result"}, result, e);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  // done must be a single-cycle pulse and result must hold afterwards.
  task automatic check_hold(input string tag, input logic [XLEN-1:0] exp_res);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    run_op("div_100_7", 2'b00, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    check_hold("div_100_7", 32'd14);
    run_op("rem_m100_7", 2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33, 1'b0);
    run_op("divu_m100_7", 2'b01, 32'hFFFFFF9C, 32'd7, 32'h24924916, 33, 1'b0);
    run_op("div_m100_m7", 2'b00, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 33, 1'b1);
    run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run_op("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    run_op("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b0);
    run_op("rem_m7_0", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1, 1'b0);
    run_op("divu_max_1", 2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, 1'b0);
    run_op("remu_max_max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 33, 1'b0);
    check_hold("remu_max_max", 32'd0);

    // flush during iteration 10
    run_op("div_7_2", 2'b00, 32'd7, 32'd2, 32'd3, 33, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_state", {30'd0, state_dbg}, 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("flush_no_done", n, 32'd0);
    check("flush_result_kept", result, 32'd3);
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33, 1'b0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = 2'b00; dividend = 32'd500; divisor = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    run_op("remu_10_4", 2'b11, 32'd10, 32'd4, 32'd2, 33, 1'b0);
    check_hold("remu_10_4", 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the RV32IM divide group (DIV, DIVU, REM, REMU) in the EX stage. It accepts one operation per start pulse and runs a 32-iteration restoring divider under a small FSM. While the operation is in flight it asserts busy so the hazard unit can stall IF/ID/EX. Divide-by-zero and signed overflow take a fast path that skips the iterations.

## Interface
Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  XLEN  rs1 value; sampled with start
- divisor  in  XLEN  rs2 value; sampled with start
- flush  in  1  synchronous abort from branch/exception logic
- busy  out  1  operation in flight; drives the pipeline stall
- done  out  1  one-cycle pulse; result valid in the same cycle
- result  out  XLEN  quotient or remainder, held until the next done

## Operation
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n. Reset sets state=IDLE, busy=0, done=0, result=0, and iteration counter=0.
- States: IDLE, CALC, FIN.
- IDLE, start=1, flush=0:
  - Latch op.
  - Latch the magnitudes of dividend and divisor. Signed ops take the absolute value; unsigned ops take the raw value.
  - Latch the sign fixups:
    - quotient negative = dividend[31] XOR divisor[31], signed ops only;
    - remainder negative = dividend[31], signed ops only.
  - divisor==0: precompute quotient=all ones, remainder=dividend. Go to FIN.
  - Signed op with dividend=0x80000000 and divisor=0xFFFFFFFF: precompute quotient=0x80000000, remainder=0. Go to FIN.
  - Otherwise: clear the partial remainder, load counter=XLEN-1, go to CALC.
- CALC, once per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from rem, using an XLEN+1 bit subtract.
  - If the result is non-negative, take the difference and set the quo LSB=1.
  - Decrement the counter. When counter==0, go to FIN.
- FIN:
  - Apply the sign fixups (two's-complement negate) to the non-special path.
  - Select quo for DIV/DIVU or rem for REM/REMU, and register it into result.
  - done=1 for one cycle, busy=0, go to IDLE.
- busy=1 exactly when state is CALC or FIN.
- start while busy: ignored, with no queuing. The pipeline holds the instruction via the stall.
- flush in any state: go to IDLE at the next edge, busy=0, no done, result unchanged. If flush and start occur together in IDLE, flush wins and the request is dropped.
- reset_n low mid-operation: outputs return to reset values immediately, with no done.

## Timing
- Edge numbering: E0 is the edge that samples start in IDLE.
- Normal path:
  - E1..E32 perform the iterations; E32 moves to FIN.
  - E33 registers the result, asserts done, and deasserts busy.
  - busy is high from after E0 until E33. done is visible for one cycle after E33.
- Fast path (divisor zero or overflow):
  - E0 goes to FIN.
  - E1 registers the result and asserts done.
  - busy is high for one cycle only.
- Back-to-back: a start sampled at the edge after the done edge (E34, or E2 on the fast path) is accepted. No extra idle cycle is required.
- result is stable between done pulses.
- done is never asserted without a preceding accepted start.

## Test plan
- DIV 100/7: after E0, busy=1 for 33 cycles; at E33, done=1 and result=14 (0x0000000E).
- REM -100/7 (dividend 0xFFFFFF9C): result 0xFFFFFFFE (-2) at E33. DIVU with the same operands: result 0x24924916.
- DIVU 5/0: done at E1, result 0xFFFFFFFF. REMU 5/0: result 5.
- DIV 0x80000000 / 0xFFFFFFFF: done at E1, result 0x80000000. REM with the same operands: result 0.
- flush asserted during iteration 10:
  - busy falls at the next edge, no done pulse, result keeps its prior value;
  - a subsequent DIVU 9/3 returns 3 at E33.
- reset_n pulled low mid-CALC: busy, done and result read 0 immediately; a start of REMU 10/4 after release returns 2.
